// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1/8O1 when UART_RX_PARITY_EN is defined),
// LSB first, DIV clocks per bit, one-byte holding register with a
// valid/ready handshake toward the command logic.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> a parity bit follows data bit 7 (11-bit frame), checked
//                against ^data ^ PARITY_ODD
//   undefined -> 10-bit frame, parity_err tied low
//
// state  | meaning
// IDLE   | waiting for a 1->0 fall on the synchronized line
// START  | timing to mid start bit, rejects glitches
// DATA   | sampling data bits 0..7 at mid-bit
// PARITY | sampling the parity bit (feature builds only)
// STOP   | sampling the stop bit, leaves at mid-stop
module uart_rx #(
  parameter int DIV        = 434,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int BW = $clog2(DIV);
  localparam logic [BW-1:0] RELOAD = BW'(DIV - 1);
  localparam logic [BW-1:0] HALF   = BW'(DIV / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nx;
  logic          rx_m, rx_s, rx_d;
  logic [BW-1:0] baud, baud_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          pend, pend_nx;
  logic          ferr_nx;
  logic          fall, sample;
`ifdef UART_RX_PARITY_EN
  logic          par, par_nx;
  logic          perr_nx;
`endif

  assign fall   = rx_d & ~rx_s;
  assign sample = (baud == '0);
  assign busy   = (state != IDLE);

  // two-flop synchronizer plus a delayed copy for fall detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud      <= '0;
      idx       <= '0;
      shift     <= '0;
      pend      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par        <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      baud      <= baud_nx;
      idx       <= idx_nx;
      shift     <= shift_nx;
      pend      <= pend_nx;
      frame_err <= ferr_nx;
`ifdef UART_RX_PARITY_EN
      par        <= par_nx;
      parity_err <= perr_nx;
`endif
    end
  end

  // next-state, bit sampling and end-of-frame classification
  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    idx_nx   = idx;
    shift_nx = shift;
    pend_nx  = 1'b0;
    ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nx   = par;
    perr_nx  = 1'b0;
`endif
    if (!ena) begin
      state_nx = IDLE;
      baud_nx  = '0;
      idx_nx   = '0;
    end else if (state == IDLE) begin
      if (fall) begin
        baud_nx  = HALF;
        state_nx = START;
      end
    end else begin
      baud_nx = sample ? RELOAD : baud - BW'(1);
      if (sample) begin
        case (state)
          START: begin
            if (rx_s) begin
              state_nx = IDLE;
            end else begin
              state_nx = DATA;
              idx_nx   = '0;
            end
          end
          DATA: begin
            shift_nx[idx] = rx_s;
            idx_nx        = idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_nx = PARITY;
`else
              state_nx = STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            par_nx   = rx_s;
            state_nx = STOP;
          end
`endif
          STOP: begin
            state_nx = IDLE;
            // framing has priority; only a clean frame reaches the holding register
            if (!rx_s) begin
              ferr_nx = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par != (^shift ^ PARITY_ODD)) begin
              perr_nx = 1'b1;
`endif
            end else begin
              pend_nx = 1'b1;
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  // PARITY_ODD has no effect without the parity feature
  assign parity_err = 1'b0 & PARITY_ODD;
`endif

  // holding register and handshake; a good byte is offered the cycle after the stop sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (pend && (!valid || ready)) begin
        data  <= shift;
        valid <= 1'b1;
      end else begin
        if (pend) overrun <= 1'b1;
        if (valid && ready) valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1 frame (8E1/8O1 with optional feature), LSB first, fixed DIV clocks per bit.
- Counterpart to the sensor hub's uart_tx. Used for host-to-hub commands and for loopback test of the TX path.
- Output side is a one-byte holding register with a valid/ready handshake to the command logic.

Parameters:
- DIV, 434, clock cycles per bit (50 MHz / 115200). Must be >= 4.
- PARITY_ODD, 0, with UART_RX_PARITY_EN defined: 0 = even parity, 1 = odd parity. Ignored otherwise.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, active-low, synchronous
- ena  input  1  block enable; low forces idle
- rx  input  1  asynchronous serial line, idle high
- data  output  8  received byte, stable while valid=1
- valid  output  1  data holds an unconsumed byte
- ready  input  1  consumer accepts byte when valid&&ready
- busy  output  1  frame reception in progress (state != IDLE)
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: good byte dropped because holding register full
- parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without feature)

Behaviour:
- Reset is sampled on posedge clk only, active-low. Reset values:
  - data=0, valid=0, busy=0, all error pulses=0.
  - Synchronizer flops=1, state=IDLE, bit counter=0, baud counter=0.
- Input path: rx goes through a 2-flop synchronizer (rx_s); the fall detector uses rx_s and a registered copy of rx_s.
- Baud counter: down-counter of width $clog2(DIV). A sample point occurs when it reaches 0, after which it reloads DIV-1.
- States:
  - IDLE: a fall on rx_s (1 then 0) loads the baud counter with DIV/2-1 and moves to START.
  - START: at the sample point, rx_s=1 is a glitch: go to IDLE with no flag. rx_s=0 goes to DATA with bit index 0.
  - DATA: each sample point shifts rx_s into bit[index]. After index 7, go to PARITY if the feature is compiled in, else STOP.
  - PARITY (feature only): sample the parity bit, then go to STOP.
  - STOP: sample the stop bit, then go to IDLE. The FSM leaves at mid-stop-bit. Back-to-back frames are received with no gap.
- Stop sample = 0: pulse frame_err, discard the byte, valid unchanged. A line held low (break) does not retrigger, because IDLE needs a 1-to-0 fall.
- Good byte: the cycle after the stop sample, the byte is accepted if valid=0 or valid&&ready holds that cycle.
  - Accepted: load data and set valid=1.
  - Not accepted: pulse overrun. data and valid keep the old byte.
- Handshake: valid drops the cycle after valid&&ready, unless a new byte loads in that same cycle (valid stays 1, data updates). data changes only on load.
- Latency: valid rises 1 clk after the stop-bit sample cycle, which is about DIV*9.5 + 3 clks after the rx fall.
- Error priority: frame_err is checked before parity_err. At most one error pulse per frame.
- ena=0: state to IDLE, busy=0, baud and bit counters cleared, any partial frame aborted with no flag. valid and data are retained, and the handshake still works.
- rst_n low mid-frame: all outputs go to reset values on the next clk edge, and the partial byte is lost.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after data bit 7. The frame is 11 bits.
  - Expected parity bit = ^data ^ PARITY_ODD.
  - On mismatch with a good stop bit: pulse parity_err, discard the byte, no overrun check.
- Undefined: no PARITY state, 10-bit frame, parity_err held 0.

Test Plan:
- DIV=8, send 0xA5 (8N1), ready=1 -> data=0xA5, valid high one cycle, busy falls at mid-stop, no error pulses.
- DIV=8, ready=0, send 0x3C then 0xC3 back-to-back -> data stays 0x3C, valid stays 1, overrun pulses once. Then ready=1 -> valid drops 1 cycle later.
- DIV=8, rx low pulse of 2 clks -> START sample sees 1, back to IDLE, valid=0, no flags. Then send 0x00 with stop bit forced 0 -> frame_err pulse, valid=0.
- DIV=8, rst_n=0 for 1 clk after data bit 3 of 0xFF -> outputs reset. Next full frame 0x81 -> data=0x81 correct. Repeat with ena=0 mid-frame -> abort, no flag.
- UART_RX_PARITY_EN, PARITY_ODD=0, DIV=8: send 0x07 with parity 1 -> valid, data=0x07. Send 0x07 with parity 0 -> parity_err pulse, valid=0.
- DIV=434 loopback: uart_tx output drives rx, 256 bytes 0x00..0xFF -> every byte received in order, no flags.
